// File: rtl/pio_access_ctrl_pkg.sv
// ============================================================================
// pio_access_ctrl_pkg : FSM states, register addresses and request context
// Rev 1.0
// ============================================================================
`default_nettype none

package pio_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4
  } state_e;

  localparam logic [3:0] ADR_DATA    = 4'b0000;
  localparam logic [3:0] ADR_DEVHEAD = 4'b0110;
  localparam int         DEV_BIT     = 4;

  typedef struct packed {
    logic        we;
    logic [3:0]  adr;
    logic [15:0] wdat;
    logic        gnt;
  } req_ctx_t;

  // Only the data register benefits from the per-device fast timing.
  function automatic logic use_fast(input logic [3:0] adr, input logic dev,
                                    input logic f0_en, input logic f1_en);
    return (adr == ADR_DATA) && (dev ? f1_en : f0_en);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pio_access_ctrl_if.sv
// ============================================================================
// pio_access_ctrl_if : requester, timing-controller and pad signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface pio_access_ctrl_if #(
  parameter int TWIDTH = 8
);
  logic              req0, we0, ack0;
  logic [3:0]        adr0;
  logic [15:0]       wdat0;
  logic              req1, we1, ack1;
  logic [3:0]        adr1;
  logic [15:0]       wdat1;
  logic [15:0]       rdat;
  logic [TWIDTH-1:0] cmp_t1, cmp_t2, cmp_t4, cmp_teoc;
  logic              cmp_iordy;
  logic [TWIDTH-1:0] f0_t1, f0_t2, f0_t4, f0_teoc;
  logic              f0_en, f0_iordy;
  logic [TWIDTH-1:0] f1_t1, f1_t2, f1_t4, f1_teoc;
  logic              f1_en, f1_iordy;
  logic              t_go, t_we, t_iordy_en, t_done, t_dstrb;
  logic [TWIDTH-1:0] t_T1, t_T2, t_T4, t_Teoc;
  logic [2:0]        DA;
  logic              CS0n, CS1n, dev;
  logic [15:0]       DD_o, DD_i;

  modport slave (
    input  req0, we0, adr0, wdat0, req1, we1, adr1, wdat1,
    input  cmp_t1, cmp_t2, cmp_t4, cmp_teoc, cmp_iordy,
    input  f0_t1, f0_t2, f0_t4, f0_teoc, f0_en, f0_iordy,
    input  f1_t1, f1_t2, f1_t4, f1_teoc, f1_en, f1_iordy,
    input  t_done, t_dstrb, DD_i,
    output ack0, ack1, rdat, t_go, t_we, t_T1, t_T2, t_T4, t_Teoc, t_iordy_en,
    output DA, CS0n, CS1n, DD_o, dev
  );

  modport master (
    output req0, we0, adr0, wdat0, req1, we1, adr1, wdat1,
    output cmp_t1, cmp_t2, cmp_t4, cmp_teoc, cmp_iordy,
    output f0_t1, f0_t2, f0_t4, f0_teoc, f0_en, f0_iordy,
    output f1_t1, f1_t2, f1_t4, f1_teoc, f1_en, f1_iordy,
    output t_done, t_dstrb, DD_i,
    input  ack0, ack1, rdat, t_go, t_we, t_T1, t_T2, t_T4, t_Teoc, t_iordy_en,
    input  DA, CS0n, CS1n, DD_o, dev
  );
endinterface

`default_nettype wire

// File: rtl/pio_rr_arb2.sv
// ============================================================================
// pio_rr_arb2 : two-way round-robin arbiter, last winner loses a tie
// Rev 1.0
// ============================================================================
`default_nettype none

module pio_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pio_access_ctrl.sv
// ============================================================================
// pio_access_ctrl : sequences ATA PIO cycles from two requesters onto one
// PIO timing controller.   Rev 1.0
// ============================================================================
`default_nettype none

module pio_access_ctrl
  import pio_access_ctrl_pkg::*;
#(
  parameter int TWIDTH = 8
) (
  input  logic               clk,
  input  logic               nReset,
  input  logic               rst,
  pio_access_ctrl_if.slave   bus
);

  localparam int TSW = 4 * TWIDTH + 1;

  state_e         state_q, state_d;
  req_ctx_t       ctx_q, ctx_d;
  logic [TSW-1:0] tset_q, tset_d;
  logic [15:0]    rdat_q;
  logic           dev_q;
  logic           last_q;
  logic [1:0]     gnt;

  pio_rr_arb2 u_arb (
    .req_i  ({bus.req1, bus.req0}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    ctx_d.gnt  = gnt[1];
    ctx_d.we   = gnt[1] ? bus.we1   : bus.we0;
    ctx_d.adr  = gnt[1] ? bus.adr1  : bus.adr0;
    ctx_d.wdat = gnt[1] ? bus.wdat1 : bus.wdat0;
    tset_d = {bus.cmp_t1, bus.cmp_t2, bus.cmp_t4, bus.cmp_teoc, bus.cmp_iordy};
    if (use_fast(ctx_d.adr, dev_q, bus.f0_en, bus.f1_en)) begin
      tset_d = dev_q ? {bus.f1_t1, bus.f1_t2, bus.f1_t4, bus.f1_teoc, bus.f1_iordy}
                     : {bus.f0_t1, bus.f0_t2, bus.f0_t4, bus.f0_teoc, bus.f0_iordy};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|gnt) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (bus.t_done) state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // last_q resets to 1 so that req0 wins the very first tie.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      ctx_q   <= '0;
      tset_q  <= '0;
      rdat_q  <= '0;
      dev_q   <= 1'b0;
      last_q  <= 1'b1;
    end else if (rst) begin
      state_q <= ST_IDLE;
      ctx_q   <= '0;
      tset_q  <= '0;
      rdat_q  <= '0;
      dev_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && |gnt) begin
        ctx_q  <= ctx_d;
        tset_q <= tset_d;
      end
      if (state_q == ST_WAIT && bus.t_dstrb && !ctx_q.we) begin
        rdat_q <= bus.DD_i;
      end
      if (state_q == ST_ACK) begin
        last_q <= ctx_q.gnt;
        if (ctx_q.we && ctx_q.adr == ADR_DEVHEAD) begin
          dev_q <= ctx_q.wdat[DEV_BIT];
        end
      end
    end
  end

  assign bus.ack0 = (state_q == ST_ACK) && !ctx_q.gnt;
  assign bus.ack1 = (state_q == ST_ACK) &&  ctx_q.gnt;
  assign bus.t_go = (state_q == ST_START);
  assign bus.t_we = (state_q != ST_IDLE) && ctx_q.we;
  assign bus.rdat = rdat_q;
  assign bus.dev  = dev_q;
  assign bus.DA   = ctx_q.adr[2:0];
  assign bus.CS0n = (state_q == ST_IDLE) ||  ctx_q.adr[3];
  assign bus.CS1n = (state_q == ST_IDLE) || !ctx_q.adr[3];
  assign bus.DD_o = ctx_q.wdat;
  assign {bus.t_T1, bus.t_T2, bus.t_T4, bus.t_Teoc, bus.t_iordy_en} = tset_q;

endmodule

`default_nettype wire
